// File: rtl/systolic_tile_sequencer_pkg.sv
// Shared types and constants for the systolic tile sequencer.
`ifndef N_ROWS
`define N_ROWS 4
`endif
`ifndef N_COLUMNS
`define N_COLUMNS 4
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

package sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LATCH,
        STREAM,
        FLUSH,
        DONE
    } seq_state_t;

    // Cycles for the last activation to drain out of the array pipeline.
    localparam int unsigned FLUSH_CYCLES = `N_ROWS + `N_COLUMNS - 1;

    // One weight row as presented to the array: lane c is bits [c*WIDTH +: WIDTH].
    typedef logic [`N_COLUMNS-1:0][`WIDTH-1:0] w_row_t;

    // Bits needed for a counter that must hold the value max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/systolic_tile_sequencer_load_counter.sv
// Up-counter with synchronous clear and a terminal flag when the count equals limit.
module load_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         terminal
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear has priority over counting.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == limit);

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer: loads one weight tile into the array, latches it, streams
// activation vectors, waits for the pipeline to drain and reports completion.
module systolic_tile_sequencer
    import sequencer_pkg::*;
#(
    parameter int unsigned N_ROWS    = `N_ROWS,
    parameter int unsigned N_COLUMNS = `N_COLUMNS,
    parameter int unsigned WIDTH     = `WIDTH,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic [ADDR_W-1:0]                 base_addr,
    input  logic [15:0]                       n_vectors,
    output logic                              busy,
    output logic                              done,
    output logic                              wmem_rd_en,
    output logic [ADDR_W-1:0]                 wmem_addr,
    input  logic [N_COLUMNS*WIDTH-1:0]        wmem_rd_data,
    output logic                              w_shift_en,
    output logic [N_COLUMNS-1:0][WIDTH-1:0]   w_row,
    output logic                              w_latch,
    output logic                              act_req,
    input  logic                              act_ack
);

    localparam int unsigned ROW_W = cnt_width(N_ROWS);
    localparam int unsigned FL_W  = cnt_width(FLUSH_CYCLES);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       nvec_q, nvec_d;
    logic              shift_q, shift_d;

    logic rd_en;
    logic row_term;
    logic beat_term;
    logic flush_term;

    // Reads issued in the current LOAD; terminal once all rows have been requested.
    load_counter #(.W(ROW_W)) u_row_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q != LOAD),
        .en       (rd_en),
        .limit    (ROW_W'(N_ROWS)),
        .terminal (row_term)
    );

    // Accepted activation beats; terminal on the final expected beat.
    load_counter #(.W(16)) u_beat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q != STREAM),
        .en       (act_req && act_ack),
        .limit    (nvec_q - 16'd1),
        .terminal (beat_term)
    );

    // Drain cycles spent in FLUSH.
    load_counter #(.W(FL_W)) u_flush_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q != FLUSH),
        .en       (state_q == FLUSH),
        .limit    (FL_W'(FLUSH_CYCLES - 1)),
        .terminal (flush_term)
    );

    // Next-state, captured-register and output decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        nvec_d  = nvec_q;
        busy    = 1'b1;
        done    = 1'b0;
        rd_en   = 1'b0;
        w_latch = 1'b0;
        act_req = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start && !abort) begin
                    addr_d  = base_addr;
                    nvec_d  = n_vectors;
                    state_d = LOAD;
                end
            end
            // LOAD holds one extra cycle after the last read so its data can shift in.
            LOAD: begin
                if (!row_term) begin
                    rd_en  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                w_latch = 1'b1;
                state_d = (nvec_q == 16'd0) ? DONE : STREAM;
            end
            STREAM: begin
                act_req = 1'b1;
                if (act_ack && beat_term) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_term) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
        end

        // A read in flight when abort arrives never reaches the weight chain.
        shift_d = rd_en && !abort;
    end

    // State and captured registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            nvec_q  <= '0;
            shift_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            nvec_q  <= nvec_d;
            shift_q <= shift_d;
        end
    end

    assign wmem_rd_en = rd_en;
    assign wmem_addr  = rd_en ? addr_q : '0;
    assign w_shift_en = shift_q;
    assign w_row      = wmem_rd_data;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Scoreboard bench for systolic_tile_sequencer: a timeline model predicts every
// output event of a tile; a negedge monitor pops and compares as events appear.
module tb_systolic_tile_sequencer;

    localparam int NR    = 4;
    localparam int NC    = 4;
    localparam int WD    = 8;
    localparam int AW    = 10;
    localparam int FLUSH = NR + NC - 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  abort;
    logic [AW-1:0]         base_addr;
    logic [15:0]           n_vectors;
    logic                  busy;
    logic                  done;
    logic                  wmem_rd_en;
    logic [AW-1:0]         wmem_addr;
    logic [NC*WD-1:0]      wmem_rd_data = '0;
    logic                  w_shift_en;
    logic [NC-1:0][WD-1:0] w_row;
    logic                  w_latch;
    logic                  act_req;
    logic                  act_ack;

    always #5 clk = ~clk;

    systolic_tile_sequencer #(
        .N_ROWS    (NR),
        .N_COLUMNS (NC),
        .WIDTH     (WD),
        .ADDR_W    (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .n_vectors    (n_vectors),
        .busy         (busy),
        .done         (done),
        .wmem_rd_en   (wmem_rd_en),
        .wmem_addr    (wmem_addr),
        .wmem_rd_data (wmem_rd_data),
        .w_shift_en   (w_shift_en),
        .w_row        (w_row),
        .w_latch      (w_latch),
        .act_req      (act_req),
        .act_ack      (act_ack)
    );

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } ev_t;

    ev_t q_rd[$], q_sh[$], q_lat[$], q_req[$], q_beat[$], q_done[$], q_busy[$];

    logic [31:0] mem [0:1023];
    bit          ack_tab [0:63];
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;
    int          c0_g;
    int          cut_g;

    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory: registered read, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (wmem_rd_en) wmem_rd_data <= mem[wmem_addr];
    end

    function automatic void chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bit ack_at(input int k);
        return (k < 64) ? ack_tab[k] : 1'b1;
    endfunction

    // Record an expected event at tile-relative cycle rel unless it lies past the cut.
    function automatic void push(input int kind, input int rel, input logic [31:0] v);
        ev_t e;
        if (rel > cut_g) return;
        e.cyc = c0_g + rel;
        e.val = v;
        case (kind)
            0: q_rd.push_back(e);
            1: q_sh.push_back(e);
            2: q_lat.push_back(e);
            3: q_req.push_back(e);
            4: q_beat.push_back(e);
            5: q_done.push_back(e);
            default: q_busy.push_back(e);
        endcase
    endfunction

    // Timeline of one tile from the accept cycle; returns the cycle of done.
    function automatic int model_tile(input logic [AW-1:0] base, input int n);
        int          beats;
        int          last;
        int          fin;
        logic [AW-1:0] a;
        for (int i = 0; i < NR; i++) begin
            a = base + AW'(i);
            push(0, 1 + i, 32'(a));
            push(1, 2 + i, mem[a]);
        end
        push(2, NR + 2, 32'd0);
        if (n == 0) begin
            fin = NR + 3;
        end else begin
            beats = 0;
            last  = NR + 3;
            for (int p = NR + 3; beats < n; p++) begin
                push(3, p, 32'd0);
                if (ack_at(p)) begin
                    push(4, p, 32'd0);
                    beats++;
                    last = p;
                end
            end
            fin = last + 1 + FLUSH;
        end
        push(5, fin, 32'd0);
        for (int k = 1; k <= fin; k++) push(6, k, 32'd0);
        return fin;
    endfunction

    function automatic void expect_ev(input int kind, input string name,
                                      input logic [31:0] val, input bit chk_val);
        ev_t e;
        bit  have;
        have = 1'b0;
        case (kind)
            0: begin have = (q_rd.size()   != 0); if (have) e = q_rd.pop_front();   end
            1: begin have = (q_sh.size()   != 0); if (have) e = q_sh.pop_front();   end
            2: begin have = (q_lat.size()  != 0); if (have) e = q_lat.pop_front();  end
            3: begin have = (q_req.size()  != 0); if (have) e = q_req.pop_front();  end
            4: begin have = (q_beat.size() != 0); if (have) e = q_beat.pop_front(); end
            5: begin have = (q_done.size() != 0); if (have) e = q_done.pop_front(); end
            default: begin have = (q_busy.size() != 0); if (have) e = q_busy.pop_front(); end
        endcase
        if (!have) begin
            chk({name, "_unexpected"}, longint'(cyc), -1);
        end else begin
            chk({name, "_cycle"}, longint'(cyc), longint'(e.cyc));
            if (chk_val) chk({name, "_value"}, longint'(val), longint'(e.val));
        end
    endfunction

    // Monitor: every asserted output must match the next expected event of its kind.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wmem_rd_en)        expect_ev(0, "rd_addr", 32'(wmem_addr), 1'b1);
            if (w_shift_en)        expect_ev(1, "shift_row", w_row, 1'b1);
            if (w_latch)           expect_ev(2, "latch", 32'd0, 1'b0);
            if (act_req)           expect_ev(3, "act_req", 32'd0, 1'b0);
            if (act_req && act_ack) expect_ev(4, "beat", 32'd0, 1'b0);
            if (done)              expect_ev(5, "done", 32'd0, 1'b0);
            if (busy)              expect_ev(6, "busy", 32'd0, 1'b0);
            else chk("idle_zero",
                     longint'({wmem_rd_en, w_shift_en, w_latch, act_req, done, wmem_addr}), 0);
        end
    end

    function automatic void fill_ack(input int mode);
        for (int k = 0; k < 64; k++) ack_tab[k] = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    // Drive one tile request; cut_kind 1 = abort, 2 = reset, at relative cycle cut.
    task automatic run_tile(input logic [AW-1:0] base, input int n,
                            input int cut_kind, input int cut, input int start2);
        int fin;
        int endk;
        c0_g  = cyc;
        cut_g = (cut_kind == 0) ? 1000000 : cut;
        fin   = model_tile(base, n);
        endk  = (cut_kind == 0) ? fin : cut;
        for (int k = 0; k <= endk; k++) begin
            start     = (k == 0) || (k == start2);
            base_addr = (k == 0) ? base : AW'($urandom);
            n_vectors = (k == 0) ? 16'(n) : 16'($urandom_range(0, 20));
            act_ack   = ack_at(k);
            abort     = (cut_kind == 1) && (k == cut);
            rst_n     = !((cut_kind == 2) && (k == cut));
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        abort   = 1'b0;
        rst_n   = 1'b1;
        act_ack = 1'b0;
    endtask

    initial begin
        int n;
        int kind;
        int cut;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        n_vectors = '0;
        act_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    longint'(busy), 0);
        chk("rst_done",    longint'(done), 0);
        chk("rst_rd_en",   longint'(wmem_rd_en), 0);
        chk("rst_addr",    longint'(wmem_addr), 0);
        chk("rst_shift",   longint'(w_shift_en), 0);
        chk("rst_latch",   longint'(w_latch), 0);
        chk("rst_act_req", longint'(act_req), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Nominal tile, then back-to-back backpressure tile.
        fill_ack(0);
        run_tile(10'h010, 3, 0, 0, -1);
        for (int k = 0; k < 64; k++) ack_tab[k] = (k < 7);
        ack_tab[7]  = 1'b0;
        ack_tab[8]  = 1'b1;
        ack_tab[9]  = 1'b0;
        ack_tab[10] = 1'b0;
        ack_tab[11] = 1'b1;
        run_tile(AW'($urandom), 2, 0, 0, -1);

        // Zero vectors with address wrap.
        fill_ack(1);
        run_tile(10'h3FE, 0, 0, 0, -1);

        // Abort mid-LOAD, then a clean tile straight after.
        fill_ack(1);
        run_tile(AW'($urandom), 4, 1, 2, -1);
        fill_ack(0);
        run_tile(10'h100, 2, 0, 0, -1);

        // Start while busy, then reset mid-STREAM.
        fill_ack(0);
        run_tile(10'h200, 5, 2, 8, 5);

        // Abort together with start in IDLE.
        run_tile(10'h055, 3, 1, 0, -1);

        // Randomised tiles with occasional abort or reset.
        repeat (30) begin
            fill_ack(1);
            n    = $urandom_range(0, 6);
            kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            cut  = $urandom_range(0, NR + 10);
            run_tile(AW'($urandom), n, kind, cut, ($urandom_range(0, 1) == 1) ? 3 : -1);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("left_rd",    longint'(q_rd.size()), 0);
        chk("left_shift", longint'(q_sh.size()), 0);
        chk("left_latch", longint'(q_lat.size()), 0);
        chk("left_req",   longint'(q_req.size()), 0);
        chk("left_beat",  longint'(q_beat.size()), 0);
        chk("left_done",  longint'(q_done.size()), 0);
        chk("left_busy",  longint'(q_busy.size()), 0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_tile_sequencer.md
# systolic_tile_sequencer

Sequences one tile of work on the systolic array: fetches the `N_ROWS` x `N_COLUMNS` weight matrix row-by-row from weight memory, shifts it into the array's shadow weight registers and commits it. It then streams a programmed number of activation vectors and waits for the array pipeline to flush before signalling completion. It sits between the host/command interface and the array datapath, and is the sole owner of the weight-load and activation-enable controls.

## Interface
- `N_ROWS`, default `` `N_ROWS ``: array rows, which is also the weight rows per tile.
- `N_COLUMNS`, default `` `N_COLUMNS ``: array columns, which is also the weights per row.
- `WIDTH`, default `` `WIDTH ``: bits per weight.
- `ADDR_W`, default 10: weight memory address width.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: tile request; sampled only in IDLE.
- `abort` in 1: synchronous cancel; highest priority after reset.
- `base_addr` in `ADDR_W`: address of weight row 0; captured on accepted `start`.
- `n_vectors` in 16: activation vectors to stream; captured on accepted `start`.
- `busy` out 1: tile in progress.
- `done` out 1: one-cycle completion pulse.
- `wmem_rd_en` out 1: weight memory read strobe.
- `wmem_addr` out `ADDR_W`: read address.
- `wmem_rd_data` in `N_COLUMNS*WIDTH`: read data, valid exactly 1 cycle after `wmem_rd_en`.
- `w_shift_en` out 1: shift `w_row` into the array weight chain.
- `w_row` out [`N_COLUMNS`][`WIDTH`]: the weight row being shifted; a direct view of `wmem_rd_data`.
- `w_latch` out 1: one-cycle pulse; the array copies shadow weights to active weights.
- `act_req` out 1: the sequencer accepts activation vectors.
- `act_ack` in 1: the activation source presents a vector this cycle.

## Operation
- FSM states: IDLE, LOAD, LATCH, STREAM, FLUSH, DONE.
- IDLE:
  - All outputs are 0.
  - `start`=1 captures `base_addr` and `n_vectors`, then enters LOAD.
- LOAD:
  - `wmem_rd_en`=1 for exactly `N_ROWS` consecutive cycles, with `wmem_addr` = base+i for i = 0..`N_ROWS`-1.
  - Address arithmetic is modulo 2^`ADDR_W`, so wrap is legal.
  - `w_shift_en` is `wmem_rd_en` delayed 1 cycle.
  - The first row shifted ends up in array row `N_ROWS`-1 and the last row shifted in array row 0.
  - After the final shift the FSM enters LATCH.
- LATCH:
  - `w_latch`=1 for one cycle.
  - The next state is STREAM, or FLUSH-skip-to-DONE if `n_vectors`==0 (see below).
- STREAM:
  - `act_req`=1.
  - Each cycle with `act_req`&&`act_ack` counts one beat; `act_ack` without `act_req` is ignored.
  - After beat `n_vectors`, `act_req` drops on the following cycle and the FSM enters FLUSH.
  - Stalls (`act_ack`=0) are unbounded.
- FLUSH: counts `FLUSH_CYCLES` = `N_ROWS`+`N_COLUMNS`-1 cycles, then enters DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `n_vectors`==0: LATCH goes directly to DONE; there is no STREAM and no FLUSH.
- `busy`=1 in every state except IDLE.
- `start` while `busy` is ignored and not queued.
- `abort`:
  - From any state, the next cycle is IDLE with all outputs 0 and no `done`.
  - An in-flight read return is discarded: no `w_shift_en` after abort.
  - `abort` together with `start` in IDLE gives IDLE.
- `rst_n`=0: the FSM goes to IDLE, all counters and captured registers clear, and all outputs are 0 on the next edge.

## Timing
Cycle 0 is the edge that accepts `start`.

- `busy` rises in cycle 1.
- `wmem_rd_en` is high in cycles 1..`N_ROWS`.
- `w_shift_en` is high in cycles 2..`N_ROWS`+1.
- `w_latch` fires in cycle `N_ROWS`+2.
- `act_req` rises in cycle `N_ROWS`+3.
- With `act_ack` held high, the last beat is in cycle `N_ROWS`+2+`n_vectors`.
- FLUSH occupies the next `FLUSH_CYCLES` cycles.
- `done` follows FLUSH directly, giving total latency `N_ROWS`+3+`n_vectors`+`FLUSH_CYCLES`.
- `busy` falls the cycle after `done`; a new `start` is accepted in that same cycle.
- `n_vectors`==0: `done` fires in cycle `N_ROWS`+3.

## Structure
- Shared package `sequencer_pkg` holds:
  - the state enum typedef `seq_state_t`;
  - `FLUSH_CYCLES`;
  - the `w_row` packed-array typedef, derived from `` `N_ROWS ``/`` `N_COLUMNS ``/`` `WIDTH `` in the common defines.
- One sub-module, `load_counter`: a parameterised up-counter with `clear`, `en` and `terminal` outputs. It is instantiated once each for the row count, beat count and flush count.

## Test plan
Configuration for all scenarios: `N_ROWS`=4, `N_COLUMNS`=4, `WIDTH`=8.

- **Nominal tile.** `start`, `base_addr`=0x010, `n_vectors`=3, `act_ack`=1:
  - addresses 0x010..0x013 appear in cycles 1..4;
  - `w_latch` fires in cycle 6;
  - beats land in cycles 7..9;
  - `done` fires in cycle 17;
  - `w_row` order matches the memory contents.
- **Backpressure.** `n_vectors`=2 with `act_ack` pattern 0,1,0,0,1 from cycle 7:
  - exactly 2 beats are counted;
  - `act_req` drops in cycle 12;
  - `done` fires 7 cycles later (cycle 19).
- **Zero vectors and address wrap.** `base_addr`=0x3FE, `n_vectors`=0:
  - addresses are 0x3FE, 0x3FF, 0x000, 0x001;
  - `done` fires in cycle 7;
  - `act_req` never rises.
- **Abort mid-LOAD.** `abort` in cycle 2:
  - IDLE in cycle 3 with no further `w_shift_en`;
  - `w_latch` and `done` never fire;
  - a new `start` in cycle 3 runs a clean tile.
- **Start while busy, then reset mid-STREAM.**
  - A second `start` in cycle 5 is ignored.
  - `rst_n`=0 in cycle 8 forces all outputs to 0 at the next edge and leaves `busy`=0.
